// File: rtl/l1_snp_rsp_ctrl.sv
// Snoop responder for the L1 controller: looks up the snooped block, writes back
// dirty data, answers the snoop bus and commits the MESI next state.
module l1_snp_rsp_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdreq_valid,
  output logic              sdreq_ready,
  input  logic [2:0]        sdreq_type,
  input  logic [ADDR_W-1:0] sdreq_addr,
  input  logic              req_lock,
  input  logic [ADDR_W-1:0] req_lock_addr,
  output logic              arr_rd_en,
  output logic [ADDR_W-1:0] arr_addr,
  input  logic              arr_hit,
  input  logic [2:0]        arr_st,
  input  logic [BLK_W-1:0]  arr_data,
  output logic              arr_wr_en,
  output logic [2:0]        arr_nxtSt,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [BLK_W-1:0]  wb_data,
  output logic              sursp_valid,
  input  logic              sursp_ready,
  output logic [2:0]        sursp_rsp,
  output logic [BLK_W-1:0]  sursp_data
);

  localparam logic [2:0] SDREQ_RD    = 3'd0;
  localparam logic [2:0] SDREQ_RFO   = 3'd1;
  localparam logic [2:0] SDREQ_INV   = 3'd2;

  localparam logic [2:0] INVALID     = 3'd0;
  localparam logic [2:0] SHARED      = 3'd1;
  localparam logic [2:0] EXCLUSIVE   = 3'd2;
  localparam logic [2:0] MODIFIED    = 3'd3;

  localparam logic [2:0] SURSP_SNOOP = 3'd1;
  localparam logic [2:0] SURSP_FETCH = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    LKUP,
    RSLV,
    WB,
    RSP
  } state_e;

  state_e             state;
  logic [2:0]         type_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         st_q;
  logic [BLK_W-1:0]   data_q;
  logic               chg_q;

  logic               hazard;
  logic [2:0]         type_norm;
  logic [2:0]         st_norm;
  logic [2:0]         nxt_st;
  logic               need_wb;
  logic               supply;

  // A snoop to the line the local controller is missing on must wait, not be dropped.
  assign hazard      = req_lock && (req_lock_addr == sdreq_addr);
  assign sdreq_ready = !rst && (state == IDLE) && !hazard;
  assign arr_rd_en   = sdreq_valid && sdreq_ready;
  assign arr_addr    = arr_rd_en ? sdreq_addr :
                       ((state == IDLE) || rst) ? '0 : addr_q;

  // The commit must coincide with the response handshake, so it cannot be
  // registered ahead of sursp_ready.
  assign arr_wr_en   = !rst && (state == RSP) && sursp_valid && sursp_ready && chg_q;

  assign type_norm = ((sdreq_type == SDREQ_RFO) || (sdreq_type == SDREQ_INV)) ?
                     sdreq_type : SDREQ_RD;
  assign st_norm   = (arr_hit && (arr_st inside {SHARED, EXCLUSIVE, MODIFIED})) ?
                     arr_st : INVALID;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    nxt_st  = INVALID;
    need_wb = (st_q == MODIFIED);
    supply  = (st_q != INVALID);
    if ((type_q == SDREQ_RD) && supply) begin
      nxt_st = SHARED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      type_q      <= SDREQ_RD;
      addr_q      <= '0;
      st_q        <= INVALID;
      data_q      <= '0;
      chg_q       <= 1'b0;
      arr_nxtSt   <= INVALID;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      sursp_valid <= 1'b0;
      sursp_rsp   <= SURSP_FETCH;
      sursp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arr_rd_en) begin
            type_q <= type_norm;
            addr_q <= sdreq_addr;
            state  <= LKUP;
          end
        end

        LKUP: begin
          st_q   <= st_norm;
          data_q <= arr_data;
          state  <= RSLV;
        end

        RSLV: begin
          arr_nxtSt  <= nxt_st;
          chg_q      <= (nxt_st != st_q);
          sursp_rsp  <= supply ? SURSP_SNOOP : SURSP_FETCH;
          sursp_data <= supply ? data_q : '0;
          if (need_wb) begin
            wb_data  <= data_q;
            wb_valid <= 1'b1;
            state    <= WB;
          end else begin
            sursp_valid <= 1'b1;
            state       <= RSP;
          end
        end

        WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            sursp_valid <= 1'b1;
            state       <= RSP;
          end
        end

        RSP: begin
          if (sursp_ready) begin
            sursp_valid <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_snp_rsp_ctrl.sv
// Directed bench for l1_snp_rsp_ctrl: cycle-exact checks of the clean, dirty,
// miss, stalled-response, address-hazard and mid-transaction reset paths.
module tb_l1_snp_rsp_ctrl;

  localparam logic [2:0] SDREQ_RD    = 3'd0;
  localparam logic [2:0] SDREQ_RFO   = 3'd1;
  localparam logic [2:0] SDREQ_INV   = 3'd2;
  localparam logic [2:0] INVALID     = 3'd0;
  localparam logic [2:0] SHARED      = 3'd1;
  localparam logic [2:0] EXCLUSIVE   = 3'd2;
  localparam logic [2:0] MODIFIED    = 3'd3;
  localparam logic [2:0] SURSP_SNOOP = 3'd1;
  localparam logic [2:0] SURSP_FETCH = 3'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdreq_valid;
  logic        sdreq_ready;
  logic [2:0]  sdreq_type;
  logic [31:0] sdreq_addr;
  logic        req_lock;
  logic [31:0] req_lock_addr;
  logic        arr_rd_en;
  logic [31:0] arr_addr;
  logic        arr_hit;
  logic [2:0]  arr_st;
  logic [31:0] arr_data;
  logic        arr_wr_en;
  logic [2:0]  arr_nxtSt;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic        sursp_valid;
  logic        sursp_ready;
  logic [2:0]  sursp_rsp;
  logic [31:0] sursp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int rd_base;

  logic        m_hit;
  logic [2:0]  m_st;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  l1_snp_rsp_ctrl #(.ADDR_W(32), .BLK_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .sdreq_valid   (sdreq_valid),
    .sdreq_ready   (sdreq_ready),
    .sdreq_type    (sdreq_type),
    .sdreq_addr    (sdreq_addr),
    .req_lock      (req_lock),
    .req_lock_addr (req_lock_addr),
    .arr_rd_en     (arr_rd_en),
    .arr_addr      (arr_addr),
    .arr_hit       (arr_hit),
    .arr_st        (arr_st),
    .arr_data      (arr_data),
    .arr_wr_en     (arr_wr_en),
    .arr_nxtSt     (arr_nxtSt),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_data       (wb_data),
    .sursp_valid   (sursp_valid),
    .sursp_ready   (sursp_ready),
    .sursp_rsp     (sursp_rsp),
    .sursp_data    (sursp_data)
  );

  // Array answers one cycle after the read strobe; otherwise it drives poison.
  always @(posedge clk) begin
    if (arr_rd_en) begin
      arr_hit  <= m_hit;
      arr_st   <= m_st;
      arr_data <= m_data;
      rd_cnt   <= rd_cnt + 1;
    end else begin
      arr_hit  <= 1'b0;
      arr_st   <= MODIFIED;
      arr_data <= '1;
    end
    if (arr_wr_en) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Presents one request in the current cycle (cycle 0) and returns in cycle 1.
  task automatic accept(input logic [2:0] t, input logic [31:0] a, input logic h,
                        input logic [2:0] s, input logic [31:0] d);
    m_hit       = h;
    m_st        = s;
    m_data      = d;
    sdreq_valid = 1'b1;
    sdreq_type  = t;
    sdreq_addr  = a;
    #1;
    check("acc_ready", sdreq_ready, 1);
    check("acc_rd_en", arr_rd_en, 1);
    check("acc_addr", arr_addr, a);
    cyc(1);
    sdreq_valid = 1'b0;
    sdreq_type  = 3'd0;
    sdreq_addr  = '0;
    #1;
    check("lkup_ready", sdreq_ready, 0);
    check("lkup_addr", arr_addr, a);
  endtask

  initial begin
    rst           = 1'b1;
    sdreq_valid   = 1'b0;
    sdreq_type    = 3'd0;
    sdreq_addr    = '0;
    req_lock      = 1'b0;
    req_lock_addr = '0;
    wb_ready      = 1'b0;
    sursp_ready   = 1'b0;
    m_hit         = 1'b0;
    m_st          = INVALID;
    m_data        = '0;

    // Reset state
    cyc(2);
    check("rst_ready", sdreq_ready, 0);
    check("rst_rd_en", arr_rd_en, 0);
    check("rst_wr_en", arr_wr_en, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_sursp_valid", sursp_valid, 0);
    check("rst_nxtst", arr_nxtSt, INVALID);
    check("rst_rsp", sursp_rsp, SURSP_FETCH);
    check("rst_wb_data", wb_data, 0);
    check("rst_sursp_data", sursp_data, 0);
    check("rst_arr_addr", arr_addr, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", sdreq_ready, 1);

    // RD to M: writeback cycle 3, response cycle 4, commit SHARED
    wb_ready    = 1'b1;
    sursp_ready = 1'b1;
    accept(SDREQ_RD, 32'h0000_1000, 1'b1, MODIFIED, 32'hDEAD_BEEF);
    cyc(1);
    check("rdm_c2_wb_valid", wb_valid, 0);
    check("rdm_c2_sursp_valid", sursp_valid, 0);
    cyc(1);
    check("rdm_c3_wb_valid", wb_valid, 1);
    check("rdm_c3_wb_data", wb_data, 32'hDEAD_BEEF);
    check("rdm_c3_sursp_valid", sursp_valid, 0);
    check("rdm_c3_wr_en", arr_wr_en, 0);
    cyc(1);
    check("rdm_c4_wb_valid", wb_valid, 0);
    check("rdm_c4_sursp_valid", sursp_valid, 1);
    check("rdm_c4_rsp", sursp_rsp, SURSP_SNOOP);
    check("rdm_c4_data", sursp_data, 32'hDEAD_BEEF);
    check("rdm_c4_wr_en", arr_wr_en, 1);
    check("rdm_c4_nxtst", arr_nxtSt, SHARED);
    cyc(1);
    check("rdm_c5_sursp_valid", sursp_valid, 0);
    check("rdm_c5_wr_en", arr_wr_en, 0);
    check("rdm_wr_cnt", wr_cnt, 1);
    check("rdm_c5_ready", sdreq_ready, 1);

    // RFO to E: no writeback, response cycle 3, commit INVALID
    accept(SDREQ_RFO, 32'h0000_2000, 1'b1, EXCLUSIVE, 32'h1234_5678);
    cyc(2);
    check("rfo_wb_valid", wb_valid, 0);
    check("rfo_sursp_valid", sursp_valid, 1);
    check("rfo_rsp", sursp_rsp, SURSP_SNOOP);
    check("rfo_data", sursp_data, 32'h1234_5678);
    check("rfo_nxtst", arr_nxtSt, INVALID);
    check("rfo_wr_en", arr_wr_en, 1);
    cyc(1);
    check("rfo_wr_cnt", wr_cnt, 2);
    check("rfo_next_ready", sdreq_ready, 1);

    // RD to tag miss (array state lines carry junk): FETCH, data 0, no commit
    accept(SDREQ_RD, 32'h0000_3000, 1'b0, MODIFIED, 32'hAAAA_5555);
    cyc(2);
    check("miss_wb_valid", wb_valid, 0);
    check("miss_sursp_valid", sursp_valid, 1);
    check("miss_rsp", sursp_rsp, SURSP_FETCH);
    check("miss_data", sursp_data, 0);
    check("miss_wr_en", arr_wr_en, 0);
    cyc(1);
    check("miss_wr_cnt", wr_cnt, 2);

    // RD to S: S -> S is not committed
    accept(SDREQ_RD, 32'h0000_3400, 1'b1, SHARED, 32'h5A5A_5A5A);
    cyc(2);
    check("rds_rsp", sursp_rsp, SURSP_SNOOP);
    check("rds_data", sursp_data, 32'h5A5A_5A5A);
    check("rds_nxtst", arr_nxtSt, SHARED);
    check("rds_wr_en", arr_wr_en, 0);
    cyc(1);
    check("rds_wr_cnt", wr_cnt, 2);

    // INV to S with the response stalled for 5 cycles
    sursp_ready = 1'b0;
    accept(SDREQ_INV, 32'h0000_4000, 1'b1, SHARED, 32'h0BAD_F00D);
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      check("inv_stall_valid", sursp_valid, 1);
      check("inv_stall_rsp", sursp_rsp, SURSP_SNOOP);
      check("inv_stall_data", sursp_data, 32'h0BAD_F00D);
      check("inv_stall_wr_en", arr_wr_en, 0);
      check("inv_stall_ready", sdreq_ready, 0);
      cyc(1);
    end
    check("inv_stall_wr_cnt", wr_cnt, 2);
    sursp_ready = 1'b1;
    #1;
    check("inv_hs_wr_en", arr_wr_en, 1);
    check("inv_hs_nxtst", arr_nxtSt, INVALID);
    cyc(1);
    check("inv_done_valid", sursp_valid, 0);
    check("inv_wr_cnt", wr_cnt, 3);

    // Address hazard: stalled 4 cycles, accepted the cycle req_lock drops
    rd_base       = rd_cnt;
    req_lock      = 1'b1;
    req_lock_addr = 32'h0000_5000;
    m_hit         = 1'b1;
    m_st          = EXCLUSIVE;
    m_data        = 32'h0000_0055;
    sdreq_valid   = 1'b1;
    sdreq_type    = SDREQ_RD;
    sdreq_addr    = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("haz_ready", sdreq_ready, 0);
      check("haz_rd_en", arr_rd_en, 0);
      cyc(1);
    end
    check("haz_rd_cnt", rd_cnt, rd_base);
    req_lock = 1'b0;
    #1;
    check("haz_rel_ready", sdreq_ready, 1);
    check("haz_rel_rd_en", arr_rd_en, 1);
    cyc(1);
    sdreq_valid = 1'b0;
    cyc(2);
    check("haz_rsp", sursp_rsp, SURSP_SNOOP);
    check("haz_data", sursp_data, 32'h0000_0055);
    check("haz_nxtst", arr_nxtSt, SHARED);
    check("haz_wr_en", arr_wr_en, 1);
    cyc(1);
    check("haz_wr_cnt", wr_cnt, 4);

    // Different address while the lock is held goes straight through
    req_lock = 1'b1;
    accept(SDREQ_RD, 32'h0000_6000, 1'b0, INVALID, 32'h0);
    cyc(2);
    check("nohaz_rsp", sursp_rsp, SURSP_FETCH);
    check("nohaz_valid", sursp_valid, 1);
    cyc(1);
    req_lock = 1'b0;

    // Reset while stuck in WB abandons the transaction
    wb_ready = 1'b0;
    accept(SDREQ_RD, 32'h0000_7000, 1'b1, MODIFIED, 32'hCAFE_F00D);
    cyc(2);
    check("rwb_c3_wb_valid", wb_valid, 1);
    check("rwb_c3_wb_data", wb_data, 32'hCAFE_F00D);
    cyc(1);
    check("rwb_c4_wb_valid", wb_valid, 1);
    rst = 1'b1;
    #1;
    check("rwb_rst_ready", sdreq_ready, 0);
    check("rwb_rst_wr_en", arr_wr_en, 0);
    cyc(1);
    check("rwb_wb_valid", wb_valid, 0);
    check("rwb_sursp_valid", sursp_valid, 0);
    check("rwb_wb_data", wb_data, 0);
    check("rwb_nxtst", arr_nxtSt, INVALID);
    rst = 1'b0;
    #1;
    check("rwb_idle_ready", sdreq_ready, 1);
    check("rwb_wr_cnt", wr_cnt, 4);

    // Fresh dirty RD after the reset completes normally
    wb_ready = 1'b1;
    accept(SDREQ_RD, 32'h0000_7100, 1'b1, MODIFIED, 32'h600D_CAFE);
    cyc(2);
    check("rd2_wb_valid", wb_valid, 1);
    check("rd2_wb_data", wb_data, 32'h600D_CAFE);
    cyc(1);
    check("rd2_sursp_valid", sursp_valid, 1);
    check("rd2_rsp", sursp_rsp, SURSP_SNOOP);
    check("rd2_data", sursp_data, 32'h600D_CAFE);
    check("rd2_nxtst", arr_nxtSt, SHARED);
    check("rd2_wr_en", arr_wr_en, 1);
    cyc(1);
    check("rd2_wr_cnt", wr_cnt, 5);

    // Illegal request type behaves as RD: E -> S
    accept(3'd6, 32'h0000_8000, 1'b1, EXCLUSIVE, 32'h1111_2222);
    cyc(2);
    check("ill_rsp", sursp_rsp, SURSP_SNOOP);
    check("ill_data", sursp_data, 32'h1111_2222);
    check("ill_nxtst", arr_nxtSt, SHARED);
    check("ill_wr_en", arr_wr_en, 1);
    cyc(1);
    check("ill_wr_cnt", wr_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
